// File: rtl/bcd_hex_display_if.sv
// Bundles the value/load handshake, display controls and the segment outputs of
// the BCD seven-segment display block.
interface bcd_hex_display_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic [WIDTH-1:0]    value;
    logic                load;
    logic                enable;
    logic                blank_zero;
    logic                blink;
    logic                busy;
    logic                done;
    logic                overflow;
    logic [DIGITS*7-1:0] hex;

    modport master (
        output value, load, enable, blank_zero, blink,
        input  busy, done, overflow, hex
    );

    modport slave (
        input  value, load, enable, blank_zero, blink,
        output busy, done, overflow, hex
    );
endinterface

// File: rtl/bcd_hex_display.sv
// Binary-to-BCD converter (one double-dabble step per clock) driving active-low
// seven-segment digits with leading-zero blanking, overflow dashes and blinking.
module bcd_hex_display #(
    parameter int WIDTH     = 16,
    parameter int DIGITS    = 5,
    parameter int BLINK_DIV = 25000000
) (
    input logic              clock,
    input logic              reset,
    bcd_hex_display_if.slave bus
);
    localparam int BW  = DIGITS * 4;
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int BCW = $clog2(BLINK_DIV);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic {S_IDLE = 1'b0, S_CONV = 1'b1} state_t;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    state_t              state_r, state_s;
    logic                start_s, finish_s;
    logic [WIDTH-1:0]    shift_r;
    logic [BW-1:0]       bcd_r, adj_s, bcd_step_s, disp_bcd_r;
    logic [CW-1:0]       count_r;
    logic                ovf_r, ovf_step_s, disp_ovf_r, valid_r, done_r;
    logic [BCW-1:0]      blink_cnt_r;
    logic                phase_r;
    logic [DIGITS*7-1:0] hex_s, hex_r;

    // One double-dabble step: add 3 to nibbles >= 5, then shift in the next bit.
    always_comb begin
        adj_s = bcd_r;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_r[4*i+:4] >= 4'd5) adj_s[4*i+:4] = bcd_r[4*i+:4] + 4'd3;
            else                       adj_s[4*i+:4] = bcd_r[4*i+:4];
        end
        bcd_step_s = {adj_s[BW-2:0], shift_r[WIDTH-1]};
        ovf_step_s = ovf_r | adj_s[BW-1];
    end

    // Conversion FSM next-state: idle until load, then WIDTH steps.
    always_comb begin
        state_s  = state_r;
        start_s  = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (bus.load) begin
                    start_s = 1'b1;
                    state_s = S_CONV;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_CONV: begin
                if (count_r == CW'(WIDTH - 1)) begin
                    finish_s = 1'b1;
                    state_s  = S_IDLE;
                end else begin
                    state_s = S_CONV;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // FSM state, conversion datapath and display registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= S_IDLE;
            shift_r    <= '0;
            bcd_r      <= '0;
            count_r    <= '0;
            ovf_r      <= 1'b0;
            done_r     <= 1'b0;
            disp_bcd_r <= '0;
            disp_ovf_r <= 1'b0;
            valid_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            done_r  <= finish_s;
            if (start_s) begin
                shift_r <= bus.value;
                bcd_r   <= '0;
                ovf_r   <= 1'b0;
                count_r <= '0;
            end else if (state_r == S_CONV) begin
                shift_r <= shift_r << 1;
                bcd_r   <= bcd_step_s;
                ovf_r   <= ovf_step_s;
                count_r <= count_r + CW'(1);
            end
            if (finish_s) begin
                disp_bcd_r <= bcd_step_s;
                disp_ovf_r <= ovf_step_s;
                valid_r    <= 1'b1;
            end
        end
    end

    // Free-running blink timebase; phase 1 means digits visible.
    always_ff @(posedge clock) begin
        if (reset) begin
            blink_cnt_r <= '0;
            phase_r     <= 1'b1;
        end else if (blink_cnt_r == BCW'(BLINK_DIV - 1)) begin
            blink_cnt_r <= '0;
            phase_r     <= ~phase_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + BCW'(1);
        end
    end

    // Segment selection; walks from the leftmost digit so leading zeros are known.
    always_comb begin : seg_sel
        logic       lead;
        logic [3:0] digit;
        hex_s = {(DIGITS*7){1'b1}};
        lead  = bus.blank_zero;
        digit = 4'd0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            digit = disp_bcd_r[4*i+:4];
            if (!bus.enable || (bus.blink && !phase_r) || !valid_r) hex_s[7*i+:7] = SEG_BLANK;
            else if (disp_ovf_r)                                    hex_s[7*i+:7] = SEG_DASH;
            else if (lead && (digit == 4'd0) && (i != 0))           hex_s[7*i+:7] = SEG_BLANK;
            else                                                    hex_s[7*i+:7] = seg7(digit);
            if (digit != 4'd0) lead = 1'b0;
            else               lead = lead;
        end
    end

    // Registered segment outputs.
    always_ff @(posedge clock) begin
        if (reset) hex_r <= {(DIGITS*7){1'b1}};
        else       hex_r <= hex_s;
    end

    assign bus.busy     = (state_r == S_CONV);
    assign bus.done     = done_r;
    assign bus.overflow = ovf_r;
    assign bus.hex      = hex_r;
endmodule

// File: tb/tb_bcd_hex_display.sv
// Bench for bcd_hex_display: a 5-digit and a 4-digit instance share stimulus and
// are checked every cycle against an integer-arithmetic display model.
module tb_bcd_hex_display;
    localparam int W  = 16;
    localparam int BD = 4;

    logic        clock = 1'b0;
    logic        reset, load, enable, blank_zero, blink;
    logic [15:0] value;
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          chk_on   = 1'b0;

    always #5 clock = ~clock;

    bcd_hex_display_if #(.WIDTH(W), .DIGITS(5)) if5 ();
    bcd_hex_display_if #(.WIDTH(W), .DIGITS(4)) if4 ();

    assign if5.value = value;  assign if4.value = value;
    assign if5.load = load;    assign if4.load = load;
    assign if5.enable = enable; assign if4.enable = enable;
    assign if5.blank_zero = blank_zero; assign if4.blank_zero = blank_zero;
    assign if5.blink = blink;  assign if4.blink = blink;

    bcd_hex_display #(.WIDTH(W), .DIGITS(5), .BLINK_DIV(BD)) u_dut5 (
        .clock(clock), .reset(reset), .bus(if5));
    bcd_hex_display #(.WIDTH(W), .DIGITS(4), .BLINK_DIV(BD)) u_dut4 (
        .clock(clock), .reset(reset), .bus(if4));

    function automatic int pow10(input int n);
        int r = 1;
        for (int k = 0; k < n; k++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] seg_of(input int n);
        case (n)
            0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
            3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
            9: return 7'b0010000;  default: return 7'b1111111;
        endcase
    endfunction

    // What a d-digit display must show for a given last-converted number and controls.
    function automatic logic [55:0] exp_hex(input int d, input bit valid, input int val,
                                            input bit en, input bit bz, input bit bl, input bit ph);
        logic [55:0] r = '0;
        for (int i = 0; i < d; i++) begin
            if (!en || (bl && !ph) || !valid) r[7*i+:7] = 7'b1111111;
            else if (val >= pow10(d))         r[7*i+:7] = 7'b0111111;
            else if (bz && i > 0 && val < pow10(i)) r[7*i+:7] = 7'b1111111;
            else                              r[7*i+:7] = seg_of((val / pow10(i)) % 10);
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", nm, act, req, $time);
        end
    endtask

    bit          m_busy = 1'b0, m_done = 1'b0, m_valid = 1'b0, m_phase = 1'b1;
    int          m_left = 0, m_val = 0, m_disp = 0, m_bcnt = 0;
    logic [55:0] m_hex5 = '0, m_hex4 = '0;

    // Reference model, advanced on each rising edge from the inputs seen at that edge.
    always @(posedge clock) begin
        if (reset) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_valid <= 1'b0; m_left <= 0;
            m_disp <= 0; m_bcnt <= 0; m_phase <= 1'b1;
            m_hex5 <= exp_hex(5, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
            m_hex4 <= exp_hex(4, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
        end else begin
            m_hex5 <= exp_hex(5, m_valid, m_disp, enable, blank_zero, blink, m_phase);
            m_hex4 <= exp_hex(4, m_valid, m_disp, enable, blank_zero, blink, m_phase);
            m_done <= 1'b0;
            if (!m_busy && load) begin
                m_busy <= 1'b1; m_left <= W; m_val <= int'(value);
            end else if (m_busy) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0; m_done <= 1'b1; m_valid <= 1'b1; m_disp <= m_val;
                end
            end
            if (m_bcnt == BD - 1) begin m_bcnt <= 0; m_phase <= !m_phase; end
            else m_bcnt <= m_bcnt + 1;
        end
    end

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clock) begin
        if (chk_on) begin
            chk("busy5", 64'(if5.busy), 64'(m_busy));
            chk("busy4", 64'(if4.busy), 64'(m_busy));
            chk("done5", 64'(if5.done), 64'(m_done));
            chk("done4", 64'(if4.done), 64'(m_done));
            chk("hex5", 64'(if5.hex), 64'(m_hex5));
            chk("hex4", 64'(if4.hex), 64'(m_hex4));
            if (!m_busy) begin
                chk("ovf5", 64'(if5.overflow), 64'(m_valid && m_disp >= pow10(5)));
                chk("ovf4", 64'(if4.overflow), 64'(m_valid && m_disp >= pow10(4)));
            end
        end
    end

    task automatic do_load(input int v);
        value = 16'(v);
        load  = 1'b1;
        @(negedge clock);
        load  = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output int cyc);
        cyc = 0;
        while (!if5.done && cyc < maxc) begin
            @(negedge clock);
            cyc++;
        end
        if (!if5.done) chk("done_timeout", 64'(0), 64'(1));
    endtask

    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] DS = 7'b0111111;

    initial begin
        int cyc;
        int np;
        reset = 1'b1; load = 1'b0; value = '0;
        enable = 1'b1; blank_zero = 1'b1; blink = 1'b0;
        repeat (2) @(negedge clock);
        chk_on = 1'b1;
        chk("rst_hex", 64'(if5.hex), 64'({5{BL}}));
        chk("rst_busy", 64'(if5.busy), 64'(0));
        reset = 1'b0;
        @(negedge clock);

        // Latency: 440
        do_load(440);
        wait_done(40, cyc);
        chk("latency", 64'(cyc), 64'(16));
        @(negedge clock);
        chk("lit440", 64'(if5.hex), 64'({BL, BL, 7'b0011001, 7'b0011001, 7'b1000000}));

        // Zero blanking
        do_load(0);
        wait_done(40, cyc);
        @(negedge clock);
        chk("lit0_bz", 64'(if5.hex), 64'({BL, BL, BL, BL, 7'b1000000}));
        blank_zero = 1'b0;
        @(negedge clock);
        chk("lit0_nobz", 64'(if5.hex), 64'({5{7'b1000000}}));
        blank_zero = 1'b1;

        // Overflow on the 4-digit instance, then recovery
        do_load(65535);
        wait_done(40, cyc);
        @(negedge clock);
        chk("ovf_flag", 64'(if4.overflow), 64'(1));
        chk("ovf_dash", 64'(if4.hex), 64'({4{DS}}));
        do_load(9999);
        wait_done(40, cyc);
        @(negedge clock);
        chk("ovf_clr", 64'(if4.overflow), 64'(0));
        chk("lit9999", 64'(if4.hex), 64'({4{7'b0010000}}));

        // Load while busy is ignored
        do_load(123);
        repeat (4) @(negedge clock);
        do_load(77);
        np = 0;
        repeat (30) begin
            if (if5.done) np++;
            @(negedge clock);
        end
        chk("one_done", 64'(np), 64'(1));
        chk("lit123", 64'(if5.hex), 64'({BL, BL, 7'b1111001, 7'b0100100, 7'b0110000}));
        do_load(77);
        wait_done(40, cyc);
        repeat (2) @(negedge clock);

        // Load held high: back-to-back conversions
        value = 16'd5000;
        load  = 1'b1;
        np = 0;
        repeat (40) begin
            @(negedge clock);
            if (if5.done) np++;
        end
        load = 1'b0;
        chk("b2b_dones", 64'(np), 64'(2));
        wait_done(40, cyc);
        repeat (2) @(negedge clock);

        // Blink, then enable low forces blank
        blink = 1'b1;
        repeat (20) @(negedge clock);
        enable = 1'b0;
        @(negedge clock);
        chk("en_blank", 64'(if5.hex), 64'({5{BL}}));
        blink = 1'b0;
        enable = 1'b1;
        repeat (2) @(negedge clock);

        // Reset mid-conversion (with load asserted during reset)
        do_load(999);
        repeat (7) @(negedge clock);
        reset = 1'b1;
        load  = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        load  = 1'b0;
        chk("rst_mid_busy", 64'(if5.busy), 64'(0));
        chk("rst_mid_hex", 64'(if5.hex), 64'({5{BL}}));
        repeat (20) @(negedge clock);
        chk("rst_stay_blank", 64'(if5.hex), 64'({5{BL}}));
        do_load(42);
        wait_done(40, cyc);
        chk("lat42", 64'(cyc), 64'(16));
        @(negedge clock);
        chk("lit42", 64'(if5.hex), 64'({BL, BL, BL, 7'b0011001, 7'b0100100}));
        repeat (3) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
